// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment display controller: bus address,
// hex font, control-word field positions and the pin bundle type.
package seg_display_pkg;

   localparam logic [31:0] SEG_DISP_ADDR = 32'h4000_0010;

   // Control-word field positions.
   localparam int unsigned EN_BIT    = 31;
   localparam int unsigned BLANK_BIT = 20;
   localparam int unsigned DP_LSB    = 16;

   localparam int unsigned DIV_W = 20;

   // Active-high segment fonts, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] FONT_0 = 7'h3F;
   localparam logic [6:0] FONT_1 = 7'h06;
   localparam logic [6:0] FONT_2 = 7'h5B;
   localparam logic [6:0] FONT_3 = 7'h4F;
   localparam logic [6:0] FONT_4 = 7'h66;
   localparam logic [6:0] FONT_5 = 7'h6D;
   localparam logic [6:0] FONT_6 = 7'h7D;
   localparam logic [6:0] FONT_7 = 7'h07;
   localparam logic [6:0] FONT_8 = 7'h7F;
   localparam logic [6:0] FONT_9 = 7'h6F;
   localparam logic [6:0] FONT_A = 7'h77;
   localparam logic [6:0] FONT_B = 7'h7C;
   localparam logic [6:0] FONT_C = 7'h39;
   localparam logic [6:0] FONT_D = 7'h5E;
   localparam logic [6:0] FONT_E = 7'h79;
   localparam logic [6:0] FONT_F = 7'h71;

   localparam logic [3:0] AN_OFF  = 4'b1111;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } pins_t;

   localparam pins_t PINS_OFF = '{an: AN_OFF, seg: SEG_OFF, dp: 1'b1};

   // One-hot-low anode pattern for a digit index.
   function automatic logic [3:0] an_select(input logic [1:0] idx);
      logic [3:0] onehot;
      onehot = 4'b0001 << idx;
      return ~onehot;
   endfunction

endpackage

// File: rtl/seg_display_decode.sv
// Hex nibble to active-high seven-segment font decoder (purely combinational).
module seg7_decode
   import seg_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segments
);

   always_comb begin
      segments = '0;
      unique case (nibble)
         4'h0: segments = FONT_0;
         4'h1: segments = FONT_1;
         4'h2: segments = FONT_2;
         4'h3: segments = FONT_3;
         4'h4: segments = FONT_4;
         4'h5: segments = FONT_5;
         4'h6: segments = FONT_6;
         4'h7: segments = FONT_7;
         4'h8: segments = FONT_8;
         4'h9: segments = FONT_9;
         4'hA: segments = FONT_A;
         4'hB: segments = FONT_B;
         4'hC: segments = FONT_C;
         4'hD: segments = FONT_D;
         4'hE: segments = FONT_E;
         4'hF: segments = FONT_F;
      endcase
   end

endmodule

// File: rtl/seg_display.sv
// Four-digit multiplexed seven-segment controller with a double-buffered
// control word that only takes effect at scan-frame boundaries.
module seg_display
   import seg_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        pending,
   output logic [31:0] shadow
);

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q;
   logic [1:0]       idx_q;
   logic [31:0]      active_q;
   logic [31:0]      staged_q;
   logic             pending_q;
   pins_t            pins_q;
   pins_t            pins_d;

   logic       tick;
   logic       frame_end;
   logic [3:0] nibble;
   logic [6:0] seg_on;
   logic       upper_zero;
   logic       blank;
   logic [3:0] dp_field;

   assign tick      = (div_cnt_q == DIV_MAX);
   assign frame_end = tick && (idx_q == 2'd3);
   assign dp_field  = active_q[DP_LSB +: 4];

   always_comb begin
      nibble = active_q[3:0];
      unique case (idx_q)
         2'd0: nibble = active_q[3:0];
         2'd1: nibble = active_q[7:4];
         2'd2: nibble = active_q[11:8];
         2'd3: nibble = active_q[15:12];
      endcase
   end

   // Blank only when this digit and every more-significant digit are zero.
   always_comb begin
      upper_zero = 1'b0;
      unique case (idx_q)
         2'd0: upper_zero = 1'b0;
         2'd1: upper_zero = (active_q[15:4] == 12'h000);
         2'd2: upper_zero = (active_q[15:8] == 8'h00);
         2'd3: upper_zero = (active_q[15:12] == 4'h0);
      endcase
   end

   assign blank = active_q[BLANK_BIT] && upper_zero;

   seg7_decode u_decode (
      .nibble   (nibble),
      .segments (seg_on)
   );

   always_comb begin
      pins_d.an  = an_select(idx_q);
      pins_d.seg = ~seg_on;
      pins_d.dp  = ~dp_field[idx_q];
      if (blank) begin
         pins_d.seg = SEG_OFF;
         pins_d.dp  = 1'b1;
      end
      if (!active_q[EN_BIT]) begin
         pins_d = PINS_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt_q <= '0;
         idx_q     <= '0;
         active_q  <= '0;
         staged_q  <= '0;
         pending_q <= 1'b0;
         pins_q    <= PINS_OFF;
      end else begin
         if (tick) begin
            div_cnt_q <= '0;
            idx_q     <= idx_q + 2'd1;
         end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
         end

         // A write landing on the boundary goes straight to the display.
         if (wr_en) begin
            staged_q <= wr_data;
            if (frame_end) begin
               active_q  <= wr_data;
               pending_q <= 1'b0;
            end else begin
               pending_q <= 1'b1;
            end
         end else if (frame_end && pending_q) begin
            active_q  <= staged_q;
            pending_q <= 1'b0;
         end

         pins_q <= pins_d;
      end
   end

   assign an      = pins_q.an;
   assign seg     = pins_q.seg;
   assign dp      = pins_q.dp;
   assign pending = pending_q;
   assign shadow  = staged_q;

   // Reserved control-word bits are carried for readback only.
   logic unused_active;
   assign unused_active = ^active_q[30:21];

endmodule
